// File: rtl/pi_est_pkg.sv
// pi_est_pkg
// Shared types and constants for the Monte-Carlo pi estimator:
// FSM state encoding, sample/coordinate widths, the unit-circle radius
// squared used by the hit test, the pipeline depth and a saturating
// increment helper for the result counters.
package pi_est_pkg;

    localparam int COORD_W    = 15;
    localparam int SAMPLE_W   = 30;
    localparam int SQ_W       = 2 * COORD_W;
    localparam int SUM_W      = SQ_W + 1;
    localparam int PIPE_DEPTH = 3;

    localparam logic [SUM_W-1:0] RADIUS_SQ = 31'h4000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pi_sq_sum_pipe.sv
// pi_sq_sum_pipe
// Squaring stage plus sum/compare of the pi estimator datapath.
// The squares are registered; the 31-bit sum and the compare against the
// radius squared are combinational on the registered squares, so the parent
// accumulates the hit on the following edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   valid      : captured sample present this cycle
//   x, y       : captured unsigned coordinates
//   res_valid  : registered squares are valid (sum/compare result usable)
//   hit        : x*x + y*y < 2^30 for the registered sample
module pi_sq_sum_pipe
    import pi_est_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               res_valid,
    output logic               hit
);

    logic [SQ_W-1:0]  x_sq;
    logic [SQ_W-1:0]  y_sq;
    logic             sq_valid;
    logic [SUM_W-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_valid <= 1'b0;
            x_sq     <= '0;
            y_sq     <= '0;
        end else begin
            sq_valid <= valid;
            if (valid) begin
                x_sq <= SQ_W'(x) * SQ_W'(x);
                y_sq <= SQ_W'(y) * SQ_W'(y);
            end
        end
    end

    // One extra bit so the sum of two 30-bit squares never wraps.
    assign sum       = {1'b0, x_sq} + {1'b0, y_sq};
    assign hit       = (sum < RADIUS_SQ);
    assign res_valid = sq_valid;

endmodule

// File: rtl/pi_estimator.sv
// pi_estimator
// Monte-Carlo pi estimator: consumes n_samples words from an external
// random generator, counts samples inside the quarter unit circle and
// reports hits/total with a one-cycle done pulse.
// Optional feature macro: PI_PERIOD_GUARD_EN -- when defined, a generator
// period_end seen on a consumed sample ends the run early and sets wrapped.
// When undefined, period_end is ignored and wrapped stays 0.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : run request (accepted in IDLE only)
//   n_samples   : samples to consume, latched on accepted start
//   rnd_data    : generator next-state word, {x, y}
//   period_end  : generator period complete flag
//   rng_ena     : consume/advance strobe to the generator
//   busy        : high in RUN and DRAIN
//   done        : one-cycle pulse, results valid
//   hits, total : in-circle count and consumed count of the last run
//   wrapped     : last run was cut short by period_end
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; results of the previous run held
// ST_RUN   | issuing samples while issued < n_lat
// ST_DRAIN | no more issues; waiting for the pipeline to empty
// ST_DONE  | one cycle, done asserted, results final
module pi_estimator
    import pi_est_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         n_samples,
    input  logic [SAMPLE_W-1:0] rnd_data,
    input  logic                period_end,
    output logic                rng_ena,
    output logic                busy,
    output logic                done,
    output logic [31:0]         hits,
    output logic [31:0]         total,
    output logic                wrapped
);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        n_lat;
    logic [31:0]        issued;
    logic               cap_valid;
    logic [COORD_W-1:0] cap_x;
    logic [COORD_W-1:0] cap_y;
    logic               res_valid;
    logic               res_hit;
    logic               period_cut;
    logic               accept;

    assign accept  = (state == ST_IDLE) && start;
    assign rng_ena = (state == ST_RUN) && (issued < n_lat);
    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);

`ifdef PI_PERIOD_GUARD_EN
    assign period_cut = rng_ena & period_end;
`else
    // period_end is referenced but masked off so the port stays in place.
    assign period_cut = rng_ena & period_end & 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (rng_ena) begin
                    if ((issued == n_lat - 32'd1) || period_cut) state_nxt = ST_DRAIN;
                end else begin
                    // Only reachable with n_lat == 0: nothing in flight.
                    state_nxt = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // The squaring stage retires on this edge, so the capture
                // stage being empty means the last accumulate happens now.
                if (!cap_valid) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat     <= '0;
            issued    <= '0;
            cap_valid <= 1'b0;
            cap_x     <= '0;
            cap_y     <= '0;
            hits      <= '0;
            total     <= '0;
            wrapped   <= 1'b0;
        end else begin
            cap_valid <= rng_ena;
            if (rng_ena) begin
                cap_x  <= rnd_data[SAMPLE_W-1:COORD_W];
                cap_y  <= rnd_data[COORD_W-1:0];
                issued <= issued + 32'd1;
            end
            if (period_cut) wrapped <= 1'b1;
            if (res_valid) begin
                total <= sat_inc(total);
                if (res_hit) hits <= sat_inc(hits);
            end
            if (accept) begin
                n_lat   <= n_samples;
                issued  <= '0;
                hits    <= '0;
                total   <= '0;
                wrapped <= 1'b0;
            end
        end
    end

    pi_sq_sum_pipe u_sq_sum_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (cap_valid),
        .x         (cap_x),
        .y         (cap_y),
        .res_valid (res_valid),
        .hit       (res_hit)
    );

endmodule

// File: tb/tb_pi_estimator.sv
module tb_pi_estimator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n_samples = '0;
    logic [29:0] rnd_data;
    logic        period_end;
    logic        rng_ena;
    logic        busy;
    logic        done;
    logic [31:0] hits;
    logic [31:0] total;
    logic        wrapped;

    logic [29:0] const_rnd = '0;
    logic [29:0] lfsr = 30'h200;
    logic        lfsr_mode = 1'b0;
    logic        lfsr_load = 1'b0;
    logic        pe_arm = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        expect_done = 1'b0;
    int          ena_cnt = 0;
    int          cyc = 0;
    int          stray_done = 0;
    int          start_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] hits;
        logic [31:0] total;
        logic        wrapped;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] n;
        logic [14:0] x;
        logic [14:0] y;
        logic [31:0] hits;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    pi_estimator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_samples  (n_samples),
        .rnd_data   (rnd_data),
        .period_end (period_end),
        .rng_ena    (rng_ena),
        .busy       (busy),
        .done       (done),
        .hits       (hits),
        .total      (total),
        .wrapped    (wrapped)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] lfsr_next(input logic [29:0] s);
        return {s[28:0], s[29] ^ s[5] ^ s[3] ^ s[0]};
    endfunction

    function automatic int unsigned model_hits(input int n);
        logic [29:0] s;
        longint unsigned xx, yy;
        int unsigned h;
        s = 30'h200;
        h = 0;
        for (int i = 0; i < n; i++) begin
            s  = lfsr_next(s);
            xx = longint'(s[29:15]);
            yy = longint'(s[14:0]);
            if (xx * xx + yy * yy < 64'd1073741824) h++;
        end
        return h;
    endfunction

    assign rnd_data   = lfsr_mode ? lfsr_next(lfsr) : const_rnd;
    assign period_end = pe_arm & rng_ena & (ena_cnt == 4);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lfsr_load) lfsr <= 30'h200;
        else if (rng_ena) lfsr <= lfsr_next(lfsr);
        if (cnt_clr) ena_cnt <= 0;
        else if (rng_ena) ena_cnt <= ena_cnt + 1;
    end

    always @(negedge clk) begin
        if (done && !expect_done) stray_done <= stray_done + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] n, input exp_t e);
        @(negedge clk);
        sb.push_back(e);
        n_samples   = n;
        start       = 1'b1;
        cnt_clr     = 1'b1;
        expect_done = 1'b1;
        start_cyc   = cyc;
        @(negedge clk);
        start   = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        exp_t e;
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done || sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done: got no scored done expected done within %0d cycles", name, budget);
            sb.delete();
            expect_done = 1'b0;
            return;
        end
        e = sb.pop_front();
        check({name, "_hits"}, hits, e.hits);
        check({name, "_total"}, total, e.total);
        check({name, "_wrapped"}, 32'(wrapped), 32'(e.wrapped));
        check({name, "_ena_count"}, ena_cnt, e.total);
        if (e.lat >= 0) check({name, "_latency"}, cyc - start_cyc, e.lat);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_hits_held"}, hits, e.hits);
        expect_done = 1'b0;
    endtask

    initial begin
        exp_t e;
        int k;
        logic [31:0] h_lfsr;

        vecs[0] = '{32'd4, 15'd0,     15'd0,     32'd4};
        vecs[1] = '{32'd3, 15'd32767, 15'd0,     32'd3};
        vecs[2] = '{32'd2, 15'd32767, 15'd32767, 32'd0};
        vecs[3] = '{32'd2, 15'd23171, 15'd23171, 32'd0};
        vecs[4] = '{32'd2, 15'd23170, 15'd23170, 32'd2};
        vecs[5] = '{32'd0, 15'd0,     15'd0,     32'd0};
        vecs[6] = '{32'd5, 15'd100,   15'd200,   32'd5};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rng_ena", 32'(rng_ena), 0);
        check("rst_hits", hits, 0);
        check("rst_total", total, 0);
        check("rst_wrapped", 32'(wrapped), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven constant-sample runs
        for (int i = 0; i < 7; i++) begin
            const_rnd = {vecs[i].x, vecs[i].y};
            e.hits    = vecs[i].hits;
            e.total   = vecs[i].n;
            e.wrapped = 1'b0;
            e.lat     = (vecs[i].n == 0) ? 2 : int'(vecs[i].n) + 3;
            launch(vecs[i].n, e);
            wait_done($sformatf("vec%0d", i), int'(vecs[i].n) + 20);
        end

        // Start during RUN is ignored; results are cleared on accepted start
        const_rnd = {15'd1, 15'd1};
        e = '{32'd20, 32'd20, 1'b0, 23};
        launch(32'd20, e);
        check("clear_hits", hits, 0);
        check("clear_total", total, 0);
        repeat (3) @(negedge clk);
        n_samples = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", 60);

        // Reset in the middle of a run
        const_rnd = '0;
        e = '{32'd100, 32'd100, 1'b0, 103};
        launch(32'd100, e);
        k = 0;
        while (ena_cnt < 10 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("midrst_reach10", 32'(ena_cnt >= 10), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_rng_ena", 32'(rng_ena), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_hits", hits, 0);
        check("midrst_total", total, 0);
        check("midrst_wrapped", 32'(wrapped), 0);
        sb.delete();
        expect_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e = '{32'd4, 32'd4, 1'b0, 7};
        launch(32'd4, e);
        wait_done("post_rst", 30);

        // period_end on the 5th consumed sample
        pe_arm = 1'b1;
`ifdef PI_PERIOD_GUARD_EN
        e = '{32'd5, 32'd5, 1'b1, 8};
`else
        e = '{32'd100, 32'd100, 1'b0, 103};
`endif
        launch(32'd100, e);
        wait_done("guard", 200);
        pe_arm = 1'b0;

        // LFSR-driven run against the bench's own hit model
        lfsr_mode = 1'b1;
        @(negedge clk);
        lfsr_load = 1'b1;
        @(negedge clk);
        lfsr_load = 1'b0;
        h_lfsr = model_hits(20000);
        e = '{h_lfsr, 32'd20000, 1'b0, 20003};
        launch(32'd20000, e);
        wait_done("lfsr", 20100);
        lfsr_mode = 1'b0;

        repeat (2) @(negedge clk);
        check("no_stray_done", stray_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
